octree_sram_burst_ctrl: RTL

- Initiator-side controller for the Octree local 8KB SRAM (req/we/addr/wdata in, rdata out, 1-cycle registered read latency).
- Accepts burst commands (base address, word count, direction).
- Write bursts: sequences a valid/ready input stream into consecutive SRAM words.
- Read bursts: streams consecutive SRAM words out on a valid/ready interface with backpressure; sits between the Octree traversal logic and the local SRAM.

---
 rtl/octree_pkg.sv | 16 +
 rtl/octree_sram_rd_fifo.sv | 49 ++++
 rtl/octree_sram_burst_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/octree_pkg.sv
// Shared definitions for the Octree local SRAM burst controller.
//   - SRAM geometry: word address width, word width and depth.
//   - Controller state encoding used by octree_sram_burst_ctrl.
package octree_pkg;

    localparam int ADDR_WIDTH = 10;
    localparam int DATA_WIDTH = 64;
    localparam int MEM_DEPTH  = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

endpackage

// File: rtl/octree_sram_rd_fifo.sv
// Two-entry registered FIFO for the read return path.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data into the tail entry
//   pop        : discard the head entry (caller only pops when count != 0)
//   head       : head entry, driven straight from the storage registers
//   count      : number of valid entries (0..2)
module octree_sram_rd_fifo #(
    parameter int DATA_WIDTH = octree_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // No bypass: a pushed word becomes visible the cycle after the push.
    assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/octree_sram_burst_ctrl.sv
// Burst controller between the Octree traversal logic and its local SRAM.
//   cmd_*   : burst command (base word address, length-1, direction)
//   wr_*    : write-data stream, one SRAM write per handshake
//   rd_*    : read-data stream with backpressure and last-beat marker
//   done_o  : one-cycle pulse when a burst completes
//   sram_*  : single-port SRAM interface, read data returns one cycle
//             after the read request
module octree_sram_burst_ctrl #(
    parameter int ADDR_WIDTH = octree_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = octree_pkg::DATA_WIDTH,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_last_o,
    output logic                  done_o,
    output logic                  sram_req_o,
    output logic                  sram_we_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

    import octree_pkg::*;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  beat_q;      // write beats accepted / read beats popped
    logic [LEN_WIDTH:0]    issue_q;     // read requests issued (can reach len+1)
    logic                  inflight_p1; // read request issued last cycle
    logic                  done_wr_p1;  // last write beat accepted last cycle

    logic                  cmd_hs;
    logic                  wr_hs;
    logic                  rd_pop;
    logic                  rd_issue;
    logic                  last_beat;
    logic [2:0]            occ;
    logic [1:0]            fifo_count;
    logic [DATA_WIDTH-1:0] fifo_head;

    assign cmd_hs    = cmd_valid_i & cmd_ready_o;
    assign wr_hs     = (state_q == WRITE) & wr_valid_i;
    assign rd_pop    = rd_valid_o & rd_ready_i;
    assign last_beat = (beat_q == len_q);

    // Occupancy the FIFO will see once the word in flight lands and the
    // current pop retires; only issue if that still leaves a free slot, so
    // a stalled consumer can never cause a returning word to be dropped.
    assign occ      = {1'b0, fifo_count} + {2'b00, inflight_p1} - {2'b00, rd_pop};
    assign rd_issue = (state_q == READ) && (issue_q <= {1'b0, len_q}) && (occ < 3'd2);

    always_comb begin
        state_d      = state_q;
        cmd_ready_o  = 1'b0;
        wr_ready_o   = 1'b0;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = addr_q;
        sram_wdata_o = '0;
        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    state_d = cmd_we_i ? WRITE : READ;
                end
            end
            WRITE: begin
                wr_ready_o   = 1'b1;
                sram_req_o   = wr_valid_i;
                sram_we_o    = wr_valid_i;
                sram_wdata_o = wr_data_i;
                if (wr_hs && last_beat) begin
                    state_d = IDLE;
                end
            end
            READ: begin
                sram_req_o = rd_issue;
                if (rd_pop && last_beat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_valid_o = (fifo_count != 2'd0);
    assign rd_data_o  = fifo_head;
    assign rd_last_o  = rd_valid_o & last_beat;
    // Write completion is reported a cycle late; read completion coincides
    // with the pop of the final beat.
    assign done_o     = done_wr_p1 | (rd_pop & rd_last_o);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            issue_q     <= '0;
            inflight_p1 <= 1'b0;
            done_wr_p1  <= 1'b0;
        end else begin
            state_q     <= state_d;
            inflight_p1 <= rd_issue;
            done_wr_p1  <= wr_hs & last_beat;
            if (cmd_hs) begin
                addr_q  <= cmd_addr_i;
                len_q   <= cmd_len_i;
                beat_q  <= '0;
                issue_q <= '0;
            end else begin
                // Address width sets the natural wrap at the top of the SRAM.
                if (wr_hs || rd_issue) begin
                    addr_q <= addr_q + 1'b1;
                end
                if (wr_hs || rd_pop) begin
                    beat_q <= beat_q + 1'b1;
                end
                if (rd_issue) begin
                    issue_q <= issue_q + 1'b1;
                end
            end
        end
    end

    // ---- read return stage: SRAM data lands in the FIFO one cycle after issue
    octree_sram_rd_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_p1),
        .push_data (sram_rdata_i),
        .pop       (rd_pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

endmodule
